// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle control unit and the MIPS32 datapath.
//
//   opcode        IR[31:26], valid from DECODE onward
//   mem_ready     memory completes its access this cycle
//   pc_write      unconditional PC load
//   pc_write_cond PC load if ALU zero (beq)
//   i_or_d        memory address select: 0=PC, 1=ALUOut
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   ir_write      IR load
//   mem_to_reg    RF write data: 0=ALUOut, 1=MDR
//   reg_dst       RF destination: 0=rt, 1=rd
//   reg_write     RF write enable
//   alu_src_a     0=PC, 1=rs
//   alu_src_b     0=rt, 1=const 4, 2=signext imm, 3=signext imm<<2
//   alu_op        0=add, 1=sub, 2=funct-decoded
//   pc_source     0=ALU result, 1=ALUOut, 2=jump target
//   halted        control unit is halted (sticky until reset)
//   illegal       halt was caused by an unknown opcode (sticky until reset)
//   instr_count   retired-instruction count, saturating
//
// The master modport belongs to the control unit; the slave modport to the
// datapath (or a testbench standing in for it).
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, halted, illegal, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, halted, illegal, instr_count
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for a shared-ALU, unified-memory MIPS32 datapath.
// Sequences one instruction per FSM pass (FETCH -> DECODE -> ... -> FETCH),
// stalls FETCH/MEMRD/MEMWR on memory wait states, counts retired
// instructions (saturating) and halts on HALT or on an unknown opcode.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low; while low all strobes and mux
//          selects are forced to 0
//   bus    control bus (master side): opcode/mem_ready in, strobes,
//          mux selects, halted, illegal and instr_count out
//
// Parameters:
//   CNT_W    width of the retired-instruction counter
//   WAIT_EN  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored
module mc_control_fsm #(
  parameter int CNT_W   = 32,
  parameter bit WAIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  mc_control_fsm_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic             halted_q, illegal_q;
  logic [CNT_W-1:0] count_q;

  logic             rdy;
  logic             retire, halt_set, illegal_set;

  logic             pc_write_c, pc_write_cond_c, i_or_d_c, mem_read_c;
  logic             mem_write_c, ir_write_c, mem_to_reg_c, reg_dst_c;
  logic             reg_write_c, alu_src_a_c;
  logic [1:0]       alu_src_b_c, alu_op_c, pc_source_c;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign rdy = bus.mem_ready || !WAIT_EN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      count_q   <= sat_inc(count_q);
      if (halt_set)    halted_q  <= 1'b1;
      if (illegal_set) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    retire          = 1'b0;
    halt_set        = 1'b0;
    illegal_set     = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    i_or_d_c        = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_dst_c       = 1'b0;
    reg_write_c     = 1'b0;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'd0;
    alu_op_c        = 2'd0;
    pc_source_c     = 2'd0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed by the ALU while the instruction is read.
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'd1;
        if (rdy) begin
          pc_write_c = 1'b1;
          ir_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target precomputed speculatively into ALUOut.
        alu_src_b_c = 2'd3;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_HALT: begin
            state_d  = S_HALT;
            halt_set = 1'b1;
          end
          default: begin
            state_d     = S_HALT;
            halt_set    = 1'b1;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        i_or_d_c   = 1'b1;
        if (rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        i_or_d_c    = 1'b1;
        if (rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'd2;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_c     = 1'b1;
        alu_op_c        = 2'd1;
        pc_write_cond_c = 1'b1;
        pc_source_c     = 2'd1;
        state_d         = S_FETCH;
        retire          = 1'b1;
      end
      S_JUMP: begin
        pc_write_c  = 1'b1;
        pc_source_c = 2'd2;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'd2;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset aborts the current instruction immediately: nothing leaves this
  // block while rst_n is low, even before the reset edge lands.
  assign bus.pc_write      = rst_n & pc_write_c;
  assign bus.pc_write_cond = rst_n & pc_write_cond_c;
  assign bus.i_or_d        = rst_n & i_or_d_c;
  assign bus.mem_read      = rst_n & mem_read_c;
  assign bus.mem_write     = rst_n & mem_write_c;
  assign bus.ir_write      = rst_n & ir_write_c;
  assign bus.mem_to_reg    = rst_n & mem_to_reg_c;
  assign bus.reg_dst       = rst_n & reg_dst_c;
  assign bus.reg_write     = rst_n & reg_write_c;
  assign bus.alu_src_a     = rst_n & alu_src_a_c;
  assign bus.alu_src_b     = {2{rst_n}} & alu_src_b_c;
  assign bus.alu_op        = {2{rst_n}} & alu_op_c;
  assign bus.pc_source     = {2{rst_n}} & pc_source_c;
  assign bus.halted        = halted_q;
  assign bus.illegal       = illegal_q;
  assign bus.instr_count   = count_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_BAD  = 6'h15;

  logic clk;
  logic rst_n;

  mc_control_fsm_if #(.CNT_W(CW)) bus ();

  mc_control_fsm #(.CNT_W(CW), .WAIT_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[2],
  //  pc_source[2], halted, illegal}
  function automatic logic [17:0] mk(
    input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca,
    input logic [1:0] srcb, aluop, pcsrc);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca,
            srcb, aluop, pcsrc, 2'b00};
  endfunction

  // Expected strobes for each kind of cycle, read straight off the
  // behavioural description of the control unit.
  localparam logic [17:0] E_FWAIT  = mk(0,0,0,1,0,0,0,0,0,0, 2'd1,2'd0,2'd0);
  localparam logic [17:0] E_FETCH  = mk(1,0,0,1,0,1,0,0,0,0, 2'd1,2'd0,2'd0);
  localparam logic [17:0] E_DECODE = mk(0,0,0,0,0,0,0,0,0,0, 2'd3,2'd0,2'd0);
  localparam logic [17:0] E_MEMADR = mk(0,0,0,0,0,0,0,0,0,1, 2'd2,2'd0,2'd0);
  localparam logic [17:0] E_MEMRD  = mk(0,0,1,1,0,0,0,0,0,0, 2'd0,2'd0,2'd0);
  localparam logic [17:0] E_MEMWB  = mk(0,0,0,0,0,0,1,0,1,0, 2'd0,2'd0,2'd0);
  localparam logic [17:0] E_MEMWR  = mk(0,0,1,0,1,0,0,0,0,0, 2'd0,2'd0,2'd0);
  localparam logic [17:0] E_EXEC   = mk(0,0,0,0,0,0,0,0,0,1, 2'd0,2'd2,2'd0);
  localparam logic [17:0] E_ALUWB  = mk(0,0,0,0,0,0,0,1,1,0, 2'd0,2'd0,2'd0);
  localparam logic [17:0] E_BRANCH = mk(0,1,0,0,0,0,0,0,0,1, 2'd0,2'd1,2'd1);
  localparam logic [17:0] E_JUMP   = mk(1,0,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd2);
  localparam logic [17:0] E_ADDIEX = mk(0,0,0,0,0,0,0,0,0,1, 2'd2,2'd0,2'd0);
  localparam logic [17:0] E_ADDIWB = mk(0,0,0,0,0,0,0,0,1,0, 2'd0,2'd0,2'd0);
  localparam logic [17:0] E_NONE   = 18'd0;

  typedef struct {
    logic [17:0] sig;
    int          cnt;
    string       tag;
  } exp_t;

  exp_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: retired count (saturating), sticky flags.
  int m_cnt     = 0;
  bit m_halted  = 1'b0;
  bit m_illegal = 1'b0;

  logic [17:0] act;
  assign act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.pc_source, bus.halted, bus.illegal};

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [CW-1:0] ecnt;
    if (sbq.size() > 0) begin
      e    = sbq.pop_front();
      ecnt = e.cnt[CW-1:0];
      n_checks++;
      if (act === e.sig) n_pass++;
      else $display("FAIL %s outputs: got %b, expected %b (t=%0t)",
                    e.tag, act, e.sig, $time);
      n_checks++;
      if (bus.instr_count === ecnt) n_pass++;
      else $display("FAIL %s instr_count: got %0d, expected %0d (t=%0t)",
                    e.tag, bus.instr_count, ecnt, $time);
    end
  end

  // One clock cycle of stimulus: drive mem_ready, record what this cycle must
  // look like, then advance the model across the edge.
  task automatic step(input logic rdy, input logic [17:0] s, input bit ret,
                      input bit rst, input string tag);
    exp_t e;
    bus.mem_ready = rdy;
    e.sig = s | {16'd0, m_halted, m_illegal};
    e.cnt = m_cnt;
    e.tag = tag;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt     = 0;
      m_halted  = 1'b0;
      m_illegal = 1'b0;
    end else if (ret && m_cnt < CNT_MAX) begin
      m_cnt++;
    end
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step(rnd(), E_NONE, 1'b0, 1'b1, "reset");
    rst_n = 1'b1;
  endtask

  // One instruction: wf fetch wait cycles, wm memory wait cycles.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    bus.opcode = op;
    for (int i = 0; i < wf; i++) step(1'b0, E_FWAIT, 1'b0, 1'b0, "fetch_wait");
    step(1'b1, E_FETCH, 1'b0, 1'b0, "fetch");
    step(rnd(), E_DECODE, 1'b0, 1'b0, "decode");
    case (op)
      OP_R: begin
        step(rnd(), E_EXEC, 1'b0, 1'b0, "exec");
        step(rnd(), E_ALUWB, 1'b1, 1'b0, "alu_wb");
      end
      OP_LW: begin
        step(rnd(), E_MEMADR, 1'b0, 1'b0, "lw_memadr");
        for (int i = 0; i < wm; i++) step(1'b0, E_MEMRD, 1'b0, 1'b0, "memrd_wait");
        step(1'b1, E_MEMRD, 1'b0, 1'b0, "memrd");
        step(rnd(), E_MEMWB, 1'b1, 1'b0, "mem_wb");
      end
      OP_SW: begin
        step(rnd(), E_MEMADR, 1'b0, 1'b0, "sw_memadr");
        for (int i = 0; i < wm; i++) step(1'b0, E_MEMWR, 1'b0, 1'b0, "memwr_wait");
        step(1'b1, E_MEMWR, 1'b1, 1'b0, "memwr");
      end
      OP_BEQ:  step(rnd(), E_BRANCH, 1'b1, 1'b0, "branch");
      OP_J:    step(rnd(), E_JUMP, 1'b1, 1'b0, "jump");
      OP_ADDI: begin
        step(rnd(), E_ADDIEX, 1'b0, 1'b0, "addi_ex");
        step(rnd(), E_ADDIWB, 1'b1, 1'b0, "addi_wb");
      end
      default: begin
        m_halted  = 1'b1;
        m_illegal = (op != OP_HALT);
        for (int i = 0; i < 20; i++) step(rnd(), E_NONE, 1'b0, 1'b0, "halt");
      end
    endcase
  endtask

  initial begin
    logic [5:0] ops [6];
    ops[0] = OP_R;   ops[1] = OP_LW; ops[2] = OP_SW;
    ops[3] = OP_BEQ; ops[4] = OP_ADDI; ops[5] = OP_J;

    rst_n         = 1'b0;
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);

    // Directed: R-type, lw with two memory waits, sw, beq then j.
    run_instr(OP_R, 0, 0);
    run_instr(OP_LW, 0, 2);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_J, 0, 0);

    // Random instruction mix with random wait states; count saturates.
    for (int k = 0; k < 40; k++)
      run_instr(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2));

    // Saturation from a clean start: 17 addi leave the count at 15.
    do_reset(1);
    for (int k = 0; k < 17; k++) run_instr(OP_ADDI, 0, 0);

    // Reset landing while a store waits in MEMWR: no strobes, no retire.
    do_reset(1);
    bus.opcode = OP_SW;
    step(1'b1, E_FETCH, 1'b0, 1'b0, "abort_fetch");
    step(1'b0, E_DECODE, 1'b0, 1'b0, "abort_decode");
    step(1'b0, E_MEMADR, 1'b0, 1'b0, "abort_memadr");
    step(1'b0, E_MEMWR, 1'b0, 1'b0, "abort_memwr_wait");
    do_reset(1);
    run_instr(OP_R, 1, 0);

    // HALT opcode, then an unknown opcode, each cleared by a single reset edge.
    run_instr(OP_HALT, 0, 0);
    do_reset(1);
    run_instr(OP_BAD, 1, 0);
    do_reset(1);
    run_instr(OP_LW, 1, 1);

    repeat (2) @(negedge clk);
    n_checks++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion, expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
